// File: rtl/dtpu_smac_pkg.sv
// Shared definitions for the smac column accumulator: precision codes,
// accumulator FSM states and the lane-width helper.
package dtpu_smac_pkg;

  // Datapath width; the lane arithmetic is laid out for exactly 64 bits.
  localparam int DATA_WIDTH = 64;

  // Precision select codes (same encoding as the INT8/INT16/INT32/INT64 defines).
  localparam logic [3:0] PREC_INT8  = 4'd0;
  localparam logic [3:0] PREC_INT16 = 4'd1;
  localparam logic [3:0] PREC_INT32 = 4'd2;
  localparam logic [3:0] PREC_INT64 = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

  // Lane width in bits for a precision code; unknown codes fall back to 64.
  function automatic int unsigned lane_bits(input logic [3:0] prec);
    case (prec)
      PREC_INT8:  return 8;
      PREC_INT16: return 16;
      PREC_INT32: return 32;
      default:    return 64;
    endcase
  endfunction

endpackage

// File: rtl/smac_acc_fifo.sv
// Synchronous first-word-fall-through result FIFO. The head entry is visible
// on dout whenever the FIFO is non-empty; dout reads 0 when empty so the
// output bus is quiet after reset or clear.
module smac_acc_fifo
  import dtpu_smac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       sclr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  // Storage array: written on push, no reset needed since empty masks dout.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (sclr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/smac_col_accumulator.sv
// Column result accumulator: sums cfg_tiles partial sums from the last smac
// of a column, lane-wise at the latched precision, and queues each finished
// sum in a FWFT FIFO toward writeback. in_ready back-pressures the column.
// Build option: define SMAC_ACC_SAT_EN to saturate overflowing lanes instead
// of wrapping them (ovf_sticky is raised either way).
module smac_col_accumulator
  import dtpu_smac_pkg::*;
#(
  parameter int DATA_WIDTH = dtpu_smac_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int TILE_W     = 8
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          sclr,
  input  logic                          start,
  input  logic                          stop,
  input  logic [TILE_W-1:0]             cfg_tiles,
  input  logic [3:0]                    select_precision,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         res_mac_n,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          ovf_sticky,
  output logic                          partial_drop
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  acc_state_e             state_reg, state_next;
  logic [TILE_W-1:0]      tiles_reg;
  logic [3:0]             prec_reg;
  logic [DATA_WIDTH-1:0]  acc_reg;
  logic [TILE_W-1:0]      cnt_reg;
  logic                   ovf_reg;
  logic                   drop_reg;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LVL_W-1:0]       fifo_level_w;
  logic                   beat;
  logic                   last_beat;
  logic [TILE_W-1:0]      cnt_last;

  logic [DATA_WIDTH-1:0]  lane_sum_w [4];
  logic [3:0]             lane_ovf_w;
  logic [DATA_WIDTH-1:0]  lane_sum;
  logic                   lane_ovf;

  assign in_ready     = (state_reg == ACCUM) && !fifo_full && !stop;
  assign beat         = in_valid && in_ready;
  // A tile count of 0 behaves like 1: every beat completes an output.
  assign cnt_last     = (tiles_reg == '0) ? '0 : tiles_reg - 1'b1;
  assign last_beat    = beat && (cnt_reg == cnt_last);
  assign out_valid    = !fifo_empty;
  assign fifo_level   = fifo_level_w;
  assign busy         = (state_reg != IDLE);
  assign ovf_sticky   = ovf_reg;
  assign partial_drop = drop_reg;

  // Lane adders for all four precisions in parallel; gw selects lane width
  // 8<<gw, gi walks the lanes. Carries never cross a lane boundary.
  for (genvar gw = 0; gw < 4; gw++) begin : g_width
    localparam int LW = 8 << gw;
    localparam int NL = DATA_WIDTH / LW;
    logic [DATA_WIDTH-1:0] sum_w;
    logic [NL-1:0]         ovf_w;

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      logic [LW-1:0] a;
      logic [LW-1:0] b;
      logic [LW-1:0] s;
      assign a = acc_reg[gi*LW +: LW];
      assign b = res_mac_n[gi*LW +: LW];
      assign s = a + b;
      // Signed overflow: operands agree in sign but the result does not.
      assign ovf_w[gi] = (a[LW-1] == b[LW-1]) && (s[LW-1] != a[LW-1]);
`ifdef SMAC_ACC_SAT_EN
      assign sum_w[gi*LW +: LW] = !ovf_w[gi] ? s :
                                  (a[LW-1] ? {1'b1, {(LW-1){1'b0}}}
                                           : {1'b0, {(LW-1){1'b1}}});
`else
      assign sum_w[gi*LW +: LW] = s;
`endif
    end

    assign lane_sum_w[gw] = sum_w;
    assign lane_ovf_w[gw] = |ovf_w;
  end

  // Pick the adder matching the latched precision.
  always_comb begin
    lane_sum = lane_sum_w[3];
    lane_ovf = lane_ovf_w[3];
    case (lane_bits(prec_reg))
      8:  begin lane_sum = lane_sum_w[0]; lane_ovf = lane_ovf_w[0]; end
      16: begin lane_sum = lane_sum_w[1]; lane_ovf = lane_ovf_w[1]; end
      32: begin lane_sum = lane_sum_w[2]; lane_ovf = lane_ovf_w[2]; end
      default: ;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else if (sclr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start only counts in IDLE, stop only in ACCUM, and
  // DRAIN ends once the last queued result has been taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (stop)  state_next = DRAIN;
      DRAIN:   if (fifo_level_w == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, beat counter, latched configuration and sticky flags.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tiles_reg <= '0;
      prec_reg  <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      drop_reg  <= 1'b0;
    end else if (sclr) begin
      tiles_reg <= '0;
      prec_reg  <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      drop_reg  <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      tiles_reg <= cfg_tiles;
      prec_reg  <= select_precision;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      drop_reg  <= 1'b0;
    end else if (state_reg == ACCUM && stop) begin
      // An unfinished sum is thrown away and reported.
      acc_reg <= '0;
      cnt_reg <= '0;
      if (cnt_reg != '0) begin
        drop_reg <= 1'b1;
      end
    end else if (beat) begin
      if (lane_ovf) begin
        ovf_reg <= 1'b1;
      end
      if (last_beat) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= lane_sum;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  smac_acc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .sclr    (sclr),
    .push    (last_beat),
    .pop     (out_ready),
    .din     (lane_sum),
    .dout    (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level_w)
  );

endmodule

// File: tb/tb_smac_col_accumulator.sv
// Self-checking bench for smac_col_accumulator: a transaction-level model
// (lane arithmetic on integers, a queue of finished sums) is compared with
// the DUT every cycle, and directed scenarios pin literal results.
module tb_smac_col_accumulator;
  import dtpu_smac_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int TW    = 8;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          sclr = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [TW-1:0] cfg_tiles = '0;
  logic [3:0]    select_precision = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] res_mac_n = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    fifo_level;
  logic          busy;
  logic          ovf_sticky;
  logic          partial_drop;

  smac_col_accumulator #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TILE_W(TW)) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .sclr             (sclr),
    .start            (start),
    .stop             (stop),
    .cfg_tiles        (cfg_tiles),
    .select_precision (select_precision),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .res_mac_n        (res_mac_n),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .fifo_level       (fifo_level),
    .busy             (busy),
    .ovf_sticky       (ovf_sticky),
    .partial_drop     (partial_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  // Model state: mode 0=idle 1=accumulating 2=draining.
  int            m_mode = 0;
  int            m_tiles = 1;
  int            m_w = 64;
  logic [DW-1:0] m_acc = '0;
  int            m_cnt = 0;
  bit            m_ovf = 1'b0;
  bit            m_drop = 1'b0;
  logic [DW-1:0] q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int width_of(input logic [3:0] p);
    if (p == PREC_INT8)  return 8;
    if (p == PREC_INT16) return 16;
    if (p == PREC_INT32) return 32;
    return 64;
  endfunction

  // Lane-wise signed add on plain integers, with overflow detection by range.
  function automatic void lane_add(input logic [63:0] a, input logic [63:0] b, input int w,
                                   output logic [63:0] r, output bit ovf);
    logic signed [63:0] ta, tb;
    logic signed [64:0] av, bv, s, mx, mn;
    logic [63:0] mask, lane;
    r = '0;
    ovf = 1'b0;
    for (int l = 0; l < 64 / w; l++) begin
      ta = (a >> (l * w)) << (64 - w);
      tb = (b >> (l * w)) << (64 - w);
      av = ta; av = av >>> (64 - w);
      bv = tb; bv = bv >>> (64 - w);
      s  = av + bv;
      mx = (65'sd1 <<< (w - 1)) - 65'sd1;
      mn = -(65'sd1 <<< (w - 1));
      if (s > mx || s < mn) begin
        ovf = 1'b1;
`ifdef SMAC_ACC_SAT_EN
        s = (s > mx) ? mx : mn;
`endif
      end
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      lane = s[63:0] & mask;
      r = r | (lane << (l * w));
    end
  endfunction

  task automatic model_step();
    int lvl;
    bit irdy, pop, beat, o;
    logic [63:0] sum;
    if (!aresetn || sclr) begin
      m_mode = 0; m_acc = '0; m_cnt = 0; m_ovf = 0; m_drop = 0;
      q.delete();
      return;
    end
    lvl  = q.size();
    irdy = (m_mode == 1) && (lvl < DEPTH) && !stop;
    pop  = out_ready && (lvl > 0);
    beat = in_valid && irdy;
    if (pop) void'(q.pop_front());
    if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        m_tiles = (cfg_tiles == 0) ? 1 : int'(cfg_tiles);
        m_w = width_of(select_precision);
        m_acc = '0; m_cnt = 0; m_ovf = 0; m_drop = 0;
      end
    end else if (m_mode == 1) begin
      if (stop) begin
        if (m_cnt != 0) m_drop = 1;
        m_acc = '0; m_cnt = 0; m_mode = 2;
      end else if (beat) begin
        lane_add(m_acc, res_mac_n, m_w, sum, o);
        if (o) m_ovf = 1;
        m_cnt++;
        if (m_cnt == m_tiles) begin
          q.push_back(sum);
          m_acc = '0; m_cnt = 0;
        end else begin
          m_acc = sum;
        end
      end
    end else begin
      if (lvl == 0) m_mode = 0;
    end
  endtask

  // Model advances on each rising edge from the inputs held there.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every falling edge, DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (run_cmp) begin
      if (!aresetn) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {ovf_sticky, partial_drop}, 0);
      end else begin
        chk("in_ready", in_ready, (m_mode == 1) && (q.size() < DEPTH) && !stop);
        chk("out_valid", out_valid, q.size() > 0);
        chk("fifo_level", fifo_level, 64'(q.size()));
        chk("busy", busy, m_mode != 0);
        chk("ovf_sticky", ovf_sticky, m_ovf);
        chk("partial_drop", partial_drop, m_drop);
        if (q.size() > 0) chk("out_data", out_data, q[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [TW-1:0] t, input logic [3:0] p);
    start = 1; cfg_tiles = t; select_precision = p;
    step();
    start = 0; cfg_tiles = 8'd200; select_precision = PREC_INT8;
    $display("start tiles=%0d prec=%0d", t, p);
  endtask

  task automatic beat(input logic [63:0] v);
    in_valid = 1; res_mac_n = v;
    step();
    in_valid = 0;
    $display("beat data=%h", v);
  endtask

  task automatic do_stop();
    stop = 1;
    step();
    stop = 0;
    $display("stop");
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_idle actual=busy required=idle within %0d cycles", max_cycles);
    end
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 run_cmp = 1;
    @(negedge clk);
    step();
    aresetn = 1;
    step();

    // 1: INT64, three tiles, result 1 cycle after the last beat.
    out_ready = 1;
    do_start(3, PREC_INT64);
    beat(1); beat(2);
    in_valid = 1; res_mac_n = 3;
    @(negedge clk);
    chk("t1_valid_before", out_valid, 0);
    step();
    in_valid = 0;
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 64'd6);
    $display("t1 result data=%h", out_data);
    step();
    do_stop();
    wait_idle(20);

    // 2: INT8 overflow in every lane.
    out_ready = 0;
    do_start(2, PREC_INT8);
    beat(64'h7F7F_7F7F_7F7F_7F7F);
    beat(64'h0101_0101_0101_0101);
    @(negedge clk);
`ifdef SMAC_ACC_SAT_EN
    chk("t2_data", out_data, 64'h7F7F_7F7F_7F7F_7F7F);
`else
    chk("t2_data", out_data, 64'h8080_8080_8080_8080);
`endif
    chk("t2_ovf", ovf_sticky, 1);
    $display("t2 result data=%h ovf=%0b", out_data, ovf_sticky);
    out_ready = 1;
    step();
    do_stop();
    wait_idle(20);

    // 3: INT16 lanes stay independent.
    out_ready = 0;
    do_start(2, PREC_INT16);
    chk("t3_ovf_cleared", ovf_sticky, 0);
    beat(64'h0001_FFFF_8000_7FFF);
    beat(64'h0001_0001_FFFF_0001);
    @(negedge clk);
`ifdef SMAC_ACC_SAT_EN
    chk("t3_data", out_data, 64'h0002_0000_8000_7FFF);
`else
    chk("t3_data", out_data, 64'h0002_0000_7FFF_8000);
`endif
    chk("t3_ovf", ovf_sticky, 1);
    $display("t3 result data=%h", out_data);
    out_ready = 1;
    step();
    do_stop();
    wait_idle(20);

    // 4: one tile per output (tiles=0 counts as 1), fill the FIFO, then drain.
    out_ready = 0;
    do_start(0, PREC_INT64);
    for (int i = 0; i < 8; i++) beat(64'(10 + i));
    @(negedge clk);
    chk("t4_level_full", fifo_level, 8);
    chk("t4_in_ready_full", in_ready, 0);
    step();
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4_pop_valid", out_valid, 1);
      chk("t4_pop_data", out_data, 64'(10 + i));
      if (i == 1) chk("t4_in_ready_back", in_ready, 1);
      $display("t4 pop %0d data=%h", i, out_data);
      step();
    end
    do_stop();
    wait_idle(20);

    // 5: start+stop together (start wins), then stop mid-output.
    start = 1; stop = 1; cfg_tiles = 4; select_precision = PREC_INT64;
    step();
    start = 0; stop = 0;
    @(negedge clk);
    chk("t5_start_wins", busy, 1);
    step();
    beat(5); beat(6);
    do_stop();
    @(negedge clk);
    chk("t5_drop", partial_drop, 1);
    $display("t5 partial_drop=%0b", partial_drop);
    wait_idle(20);
    @(negedge clk);
    chk("t5_idle", busy, 0);
    chk("t5_level", fifo_level, 0);
    step();

    // 6a: asynchronous reset with three results queued.
    out_ready = 0;
    do_start(1, PREC_INT32);
    beat(1); beat(2); beat(3);
    @(negedge clk);
    chk("t6_level3", fifo_level, 3);
    step();
    aresetn = 0;
    @(negedge clk);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    step();
    aresetn = 1;
    @(negedge clk);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_valid", out_valid, 0);
    $display("t6 async reset level=%0d", fifo_level);
    step();

    // 6b: synchronous clear with three results queued.
    do_start(1, PREC_INT32);
    beat(4); beat(5); beat(6);
    sclr = 1;
    step();
    sclr = 0;
    @(negedge clk);
    chk("t6_sclr_level", fifo_level, 0);
    chk("t6_sclr_valid", out_valid, 0);
    chk("t6_sclr_data", out_data, 0);
    chk("t6_sclr_busy", busy, 0);
    chk("t6_sclr_in_ready", in_ready, 0);
    $display("t6 sclr level=%0d busy=%0b", fifo_level, busy);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
